// File: rtl/morse_pkg.sv
// morse_pkg: shared types and constants for the Morse code transmitter.
//   - FSM state encodings (legacy-compatible localparam constants)
//   - pattern_t: {len[2:0], sym[4:0]}, sym bit 0 sent first, 1 = dash, 0 = dot
//   - ASCII anchor constants and Morse unit multipliers
//   - unit_load(): counter preload for a duration expressed in units
package morse_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_MARK     = 3'd1;
  localparam state_t ST_SYM_GAP  = 3'd2;
  localparam state_t ST_CHAR_GAP = 3'd3;
  localparam state_t ST_WORD_GAP = 3'd4;
  localparam state_t ST_BAD      = 3'd5;

  typedef struct packed {
    logic [2:0] len;
    logic [4:0] sym;
  } pattern_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_0     = 8'h30;

  localparam int unsigned DOT_UNITS      = 1;
  localparam int unsigned DASH_UNITS     = 3;
  localparam int unsigned SYM_GAP_UNITS  = 1;
  localparam int unsigned CHAR_GAP_UNITS = 3;
  localparam int unsigned WORD_GAP_UNITS = 7;

  // Counter runs from (duration - 1) down to 0, so the preload is one less.
  function automatic int unsigned unit_load(int unsigned units, int unsigned unit_cycles);
    return units * unit_cycles - 1;
  endfunction

endpackage

// File: rtl/morse_char_rom.sv
// morse_char_rom: combinational ASCII -> Morse pattern lookup.
// Ports:
//   char_code [7:0]  ASCII character
//   valid            character is a supported letter or digit
//   pattern          {len, sym}; zero when not valid
// Optional: MORSE_TX_LOWERCASE_EN folds 'a'-'z' to 'A'-'Z' before lookup.
module morse_char_rom
  import morse_pkg::*;
(
  input  logic [7:0] char_code,
  output logic       valid,
  output pattern_t   pattern
);

  logic [7:0] folded;
  logic [7:0] letter_off;
  logic [7:0] digit_off;

  always_comb begin
    folded = char_code;
`ifdef MORSE_TX_LOWERCASE_EN
    if (char_code >= 8'h61 && char_code <= 8'h7A) begin
      folded = char_code - 8'h20;
    end
`endif
  end

  assign letter_off = folded - ASCII_A;
  assign digit_off  = folded - ASCII_0;

  always_comb begin
    valid   = 1'b1;
    pattern = '0;
    if (folded >= ASCII_A && folded <= 8'h5A) begin
      // sym is written MSB..LSB, so the first symbol sent is the rightmost bit
      case (letter_off)
        8'd0:    pattern = {3'd2, 5'b00010}; // A .-
        8'd1:    pattern = {3'd4, 5'b00001}; // B -...
        8'd2:    pattern = {3'd4, 5'b00101}; // C -.-.
        8'd3:    pattern = {3'd3, 5'b00001}; // D -..
        8'd4:    pattern = {3'd1, 5'b00000}; // E .
        8'd5:    pattern = {3'd4, 5'b00100}; // F ..-.
        8'd6:    pattern = {3'd3, 5'b00011}; // G --.
        8'd7:    pattern = {3'd4, 5'b00000}; // H ....
        8'd8:    pattern = {3'd2, 5'b00000}; // I ..
        8'd9:    pattern = {3'd4, 5'b01110}; // J .---
        8'd10:   pattern = {3'd3, 5'b00101}; // K -.-
        8'd11:   pattern = {3'd4, 5'b00010}; // L .-..
        8'd12:   pattern = {3'd2, 5'b00011}; // M --
        8'd13:   pattern = {3'd2, 5'b00001}; // N -.
        8'd14:   pattern = {3'd3, 5'b00111}; // O ---
        8'd15:   pattern = {3'd4, 5'b00110}; // P .--.
        8'd16:   pattern = {3'd4, 5'b01011}; // Q --.-
        8'd17:   pattern = {3'd3, 5'b00010}; // R .-.
        8'd18:   pattern = {3'd3, 5'b00000}; // S ...
        8'd19:   pattern = {3'd1, 5'b00001}; // T -
        8'd20:   pattern = {3'd3, 5'b00100}; // U ..-
        8'd21:   pattern = {3'd4, 5'b01000}; // V ...-
        8'd22:   pattern = {3'd3, 5'b00110}; // W .--
        8'd23:   pattern = {3'd4, 5'b01001}; // X -..-
        8'd24:   pattern = {3'd4, 5'b01101}; // Y -.--
        8'd25:   pattern = {3'd4, 5'b00011}; // Z --..
        default: valid   = 1'b0;
      endcase
    end else if (folded >= ASCII_0 && folded <= 8'h39) begin
      case (digit_off)
        8'd0:    pattern = {3'd5, 5'b11111}; // 0 -----
        8'd1:    pattern = {3'd5, 5'b11110}; // 1 .----
        8'd2:    pattern = {3'd5, 5'b11100}; // 2 ..---
        8'd3:    pattern = {3'd5, 5'b11000}; // 3 ...--
        8'd4:    pattern = {3'd5, 5'b10000}; // 4 ....-
        8'd5:    pattern = {3'd5, 5'b00000}; // 5 .....
        8'd6:    pattern = {3'd5, 5'b00001}; // 6 -....
        8'd7:    pattern = {3'd5, 5'b00011}; // 7 --...
        8'd8:    pattern = {3'd5, 5'b00111}; // 8 ---..
        8'd9:    pattern = {3'd5, 5'b01111}; // 9 ----.
        default: valid   = 1'b0;
      endcase
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/morse_code_transmitter.sv
// morse_code_transmitter: sends one ASCII character at a time as timed Morse
// key intervals with 1:3:1:3:7 unit timing.
// Parameters:
//   UNIT_CYCLES   clock cycles per Morse unit (>= 1)
// Ports:
//   clk           system clock, rising edge
//   Reset_n       synchronous active-low reset
//   char_in       ASCII character, captured on a valid/ready transfer
//   char_valid    char_in valid this cycle
//   char_ready    can accept a character (IDLE, not in reset, no Clear)
//   Clear         synchronous abort back to IDLE
//   key           tone on
//   dot_buzzer    key during a dot
//   dash_buzzer   key during a dash
//   busy          not in IDLE
//   bad_char      one-cycle pulse after an unsupported character is accepted
// Optional: MORSE_TX_LOWERCASE_EN (handled in morse_char_rom) sends 'a'-'z' as 'A'-'Z'.
module morse_code_transmitter
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 6_000_000
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       Clear,
  output logic       key,
  output logic       dot_buzzer,
  output logic       dash_buzzer,
  output logic       busy,
  output logic       bad_char
);

  localparam int unsigned CNT_W = $clog2(WORD_GAP_UNITS * UNIT_CYCLES);

  localparam logic [CNT_W-1:0] DOT_LOAD      = CNT_W'(unit_load(DOT_UNITS, UNIT_CYCLES));
  localparam logic [CNT_W-1:0] DASH_LOAD     = CNT_W'(unit_load(DASH_UNITS, UNIT_CYCLES));
  localparam logic [CNT_W-1:0] SYM_GAP_LOAD  = CNT_W'(unit_load(SYM_GAP_UNITS, UNIT_CYCLES));
  localparam logic [CNT_W-1:0] CHAR_GAP_LOAD = CNT_W'(unit_load(CHAR_GAP_UNITS, UNIT_CYCLES));
  localparam logic [CNT_W-1:0] WORD_GAP_LOAD = CNT_W'(unit_load(WORD_GAP_UNITS, UNIT_CYCLES));

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       sym_q, sym_d;
  logic [2:0]       len_q, len_d;
  logic [2:0]       idx_q, idx_d;

  logic     rom_valid;
  pattern_t rom_pattern;
  logic     transfer;
  logic     cnt_done;

  morse_char_rom u_rom (
    .char_code (char_in),
    .valid     (rom_valid),
    .pattern   (rom_pattern)
  );

  // Clear and reset also drop ready so a same-cycle transfer is never taken.
  assign char_ready = (state_q == ST_IDLE) && Reset_n && !Clear;
  assign transfer   = char_valid && char_ready;
  assign cnt_done   = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    len_d   = len_q;
    idx_d   = idx_q;

    if (Clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sym_d   = '0;
      len_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (transfer) begin
            if (char_in == ASCII_SPACE) begin
              state_d = ST_WORD_GAP;
              cnt_d   = WORD_GAP_LOAD;
            end else if (rom_valid) begin
              state_d = ST_MARK;
              sym_d   = rom_pattern.sym;
              len_d   = rom_pattern.len;
              idx_d   = '0;
              cnt_d   = rom_pattern.sym[0] ? DASH_LOAD : DOT_LOAD;
            end else begin
              state_d = ST_BAD;
              cnt_d   = '0;
            end
          end
        end

        ST_MARK: begin
          if (cnt_done) begin
            // Next symbol moves into bit 0 for the following MARK.
            sym_d = {1'b0, sym_q[4:1]};
            if ((idx_q + 3'd1) < len_q) begin
              state_d = ST_SYM_GAP;
              idx_d   = idx_q + 3'd1;
              cnt_d   = SYM_GAP_LOAD;
            end else begin
              state_d = ST_CHAR_GAP;
              cnt_d   = CHAR_GAP_LOAD;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        ST_SYM_GAP: begin
          if (cnt_done) begin
            state_d = ST_MARK;
            cnt_d   = sym_q[0] ? DASH_LOAD : DOT_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        ST_CHAR_GAP, ST_WORD_GAP: begin
          if (cnt_done) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        ST_BAD: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sym_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode registered state only.
  assign key         = (state_q == ST_MARK);
  assign dot_buzzer  = key && !sym_q[0];
  assign dash_buzzer = key && sym_q[0];
  assign busy        = (state_q != ST_IDLE);
  assign bad_char    = (state_q == ST_BAD);

endmodule

// File: tb/tb_morse_code_transmitter.sv
// Self-checking bench for morse_code_transmitter with UNIT_CYCLES = 4.
// Expected per-cycle output vectors {key, dot, dash, busy, ready, bad} are
// generated from Morse strings and queued, then popped once per cycle.
module tb_morse_code_transmitter;

  localparam int unsigned U = 4;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       Clear;
  logic       key;
  logic       dot_buzzer;
  logic       dash_buzzer;
  logic       busy;
  logic       bad_char;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q[$];

  morse_code_transmitter #(
    .UNIT_CYCLES (U)
  ) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .Clear       (Clear),
    .key         (key),
    .dot_buzzer  (dot_buzzer),
    .dash_buzzer (dash_buzzer),
    .busy        (busy),
    .bad_char    (bad_char)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] V_IDLE = 6'b000010;
  localparam logic [5:0] V_GAP  = 6'b000100;
  localparam logic [5:0] V_DOT  = 6'b110100;
  localparam logic [5:0] V_DASH = 6'b101100;
  localparam logic [5:0] V_BAD  = 6'b000101;

  function automatic logic [5:0] obs();
    return {key, dot_buzzer, dash_buzzer, busy, char_ready, bad_char};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Character as dots/dashes, then 3-unit gap, then one IDLE cycle.
  task automatic push_char(input string p);
    for (int j = 0; j < p.len(); j++) begin
      logic is_dash;
      is_dash = (p[j] == 8'h2D);
      repeat (is_dash ? 3 * U : U) exp_q.push_back(is_dash ? V_DASH : V_DOT);
      if (j < p.len() - 1) repeat (U) exp_q.push_back(V_GAP);
    end
    repeat (3 * U) exp_q.push_back(V_GAP);
    exp_q.push_back(V_IDLE);
  endtask

  task automatic push_space();
    repeat (7 * U) exp_q.push_back(V_GAP);
    exp_q.push_back(V_IDLE);
  endtask

  task automatic push_bad();
    exp_q.push_back(V_BAD);
    exp_q.push_back(V_IDLE);
  endtask

  // Called at a negedge: wait (bounded) for ready, then present the character.
  task automatic start(input logic [7:0] c);
    int n;
    n = 0;
    while (!char_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {5'b0, char_ready}, 6'b000001);
    char_in    = c;
    char_valid = 1'b1;
  endtask

  // One popped vector per cycle; valid drops and char_in is scrambled after the transfer.
  task automatic drain(input string tag);
    int i;
    i = 0;
    while (exp_q.size() > 0) begin
      logic [5:0] want;
      @(negedge clk);
      want = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, i + 1), obs(), want);
      if (i == 0) begin
        char_valid = 1'b0;
        char_in    = 8'h5A;
      end
      i++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    Reset_n    = 1'b0;
    Clear      = 1'b0;
    char_valid = 1'b0;
    char_in    = 8'h00;

    repeat (2) @(negedge clk);
    check("reset", obs(), 6'b000000);
    @(posedge clk);
    #1 Reset_n = 1'b1;
    @(negedge clk);
    check("release", obs(), V_IDLE);

    // Single dot
    start(8'h45); push_char("."); drain("E");
    // Dot then dash
    start(8'h41); push_char(".-"); drain("A");
    // Back-to-back A then T
    start(8'h41); push_char(".-"); drain("A2");
    start(8'h54); push_char("-"); drain("T_b2b");
    // Word gap
    start(8'h20); push_space(); drain("space");
    // Unsupported
    start(8'h23); push_bad(); drain("hash");
    // Longer patterns
    start(8'h39); push_char("----."); drain("9");
    start(8'h51); push_char("--.-"); drain("Q");

    // Clear during cycle 5 of T's dash
    start(8'h54);
    repeat (5) exp_q.push_back(V_DASH);
    drain("T_clr");
    Clear = 1'b1;
    @(posedge clk);
    #1 Clear = 1'b0;
    exp_q.push_back(V_IDLE);
    drain("T_clr_idle");
    start(8'h45); push_char("."); drain("E_after_clr");

    // Clear in IDLE blocks a simultaneous transfer
    Clear      = 1'b1;
    char_in    = 8'h45;
    char_valid = 1'b1;
    #1 check("clr_idle_ready", {5'b0, char_ready}, 6'b000000);
    @(posedge clk);
    #1 begin
      Clear      = 1'b0;
      char_valid = 1'b0;
    end
    exp_q.push_back(V_IDLE);
    exp_q.push_back(V_IDLE);
    drain("clr_idle_blocked");

    // Reset mid-'0'
    start(8'h30);
    repeat (6) exp_q.push_back(V_DASH);
    drain("zero_rst");
    Reset_n = 1'b0;
    #1 check("rst_ready_low", {5'b0, char_ready}, 6'b000000);
    @(posedge clk);
    #1 Reset_n = 1'b1;
    exp_q.push_back(V_IDLE);
    drain("zero_rst_idle");
    start(8'h45); push_char("."); drain("E_after_rst");

    // Lowercase
    start(8'h65);
`ifdef MORSE_TX_LOWERCASE_EN
    push_char(".");
`else
    push_bad();
`endif
    drain("lower_e");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
